// File: rtl/sseg_scan_ctrl_if.sv
`default_nettype none
//=============================================================================
// Module      : sseg_scan_ctrl_if
// Description : Write port for the per-digit hex value registers of the
//               seven-segment scan controller.
//                 wr_en   - write strobe, sampled on the controller clock
//                 wr_addr - digit index (0 = rightmost)
//                 wr_data - 4-bit hex value to store
//               master drives the port, slave (the controller) receives it.
// Revision    : 1.0 - initial release
//=============================================================================
interface sseg_scan_ctrl_if;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
//=============================================================================
// Module      : sseg_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode
//               seven-segment display. Each digit is lit for CLK_DIV cycles,
//               separated by GUARD all-off cycles to prevent ghosting.
//               Per-digit blanking, decimal points and optional leading-zero
//               suppression are applied when a slot starts.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               wr          - digit value write port (slave modport)
//               dp_mask     - 1 = decimal point lit for that digit
//               blank_mask  - 1 = digit forced dark
//               lz_suppress - 1 = blank leading zeros
//               sseg        - segments {dp,g,f,e,d,c,b,a}, active-low
//               en          - digit enables, active-low
//               digit_idx   - digit owning the current scan slot
//               frame_tick  - one-cycle pulse when the scan wraps to digit 0
// Revision    : 1.0 - initial release
//=============================================================================
module sseg_scan_ctrl #(
   parameter int CLK_DIV = 67000,
   parameter int GUARD   = 16,
   parameter int DIGITS  = 6
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   sseg_scan_ctrl_if.slave        wr,
   input  wire logic [DIGITS-1:0] dp_mask,
   input  wire logic [DIGITS-1:0] blank_mask,
   input  wire logic              lz_suppress,
   output logic      [7:0]        sseg,
   output logic      [DIGITS-1:0] en,
   output logic      [2:0]        digit_idx,
   output logic                   frame_tick
);

   // One counter serves both states, so it must hold the longer duration.
   localparam int c_CNT_MAX = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
   localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

   localparam logic [c_CNT_W-1:0] c_SHOW_LAST  = c_CNT_W'(CLK_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD - 1);
   localparam logic [2:0]         c_IDX_LAST   = 3'(DIGITS - 1);

   typedef enum logic [0:0] {
      ST_GUARD = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [3:0]         r_digit [DIGITS];
   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [7:0]         r_sseg;
   logic [DIGITS-1:0]  r_en;
   logic [2:0]         r_digit_idx;
   logic               r_frame_tick;

   // ------------------------------------------------------------------
   // Next-state wires
   // ------------------------------------------------------------------
   state_t             w_state_nxt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic [7:0]         w_sseg_nxt;
   logic [DIGITS-1:0]  w_en_nxt;
   logic [2:0]         w_idx_nxt;
   logic               w_tick_nxt;

   // Slot content for the digit currently selected by r_digit_idx
   logic [3:0]         w_cur_val;
   logic               w_cur_dark;
   logic               w_cur_dp;
   logic [7:0]         w_show_sseg;
   logic [DIGITS-1:0]  w_show_en;

   // w_dark[i] = digit i is dark by blanking or leading-zero suppression
   logic [DIGITS-1:0]  w_dark;
   // w_upper_zero[i] = digits i..DIGITS-1 all hold zero
   logic [DIGITS:1]    w_upper_zero;

   // ------------------------------------------------------------------
   // Hex to segment decode, active-low g..a with dp (bit 7) off
   // ------------------------------------------------------------------
   function automatic logic [7:0] f_decode(input logic [3:0] val);
      logic [7:0] seg;
      case (val)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

   // ------------------------------------------------------------------
   // Digit value registers. Addresses without a matching digit never
   // match the loop compare and are therefore ignored.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIGITS; i++) begin
            r_digit[i] <= 4'd0;
         end
      end else if (wr.wr_en) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (wr.wr_addr == 3'(i)) begin
               r_digit[i] <= wr.wr_data;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Darkness per digit. The leading-zero chain runs from the most
   // significant digit downward; digit 0 only honours blank_mask so a
   // value of all zeros still shows a single "0".
   // ------------------------------------------------------------------
   assign w_upper_zero[DIGITS] = 1'b1;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dark
      if (gi == 0) begin : g_lsd
         assign w_dark[gi] = blank_mask[gi];
      end else begin : g_upper
         assign w_upper_zero[gi] = (r_digit[gi] == 4'd0) && w_upper_zero[gi+1];
         assign w_dark[gi]       = blank_mask[gi] | (lz_suppress & w_upper_zero[gi]);
      end
   end

   // ------------------------------------------------------------------
   // Pattern for the digit about to be shown
   // ------------------------------------------------------------------
   always_comb begin
      w_cur_val  = 4'd0;
      w_cur_dark = 1'b1;
      w_cur_dp   = 1'b0;
      w_show_en  = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_digit_idx == 3'(i)) begin
            w_cur_val  = r_digit[i];
            w_cur_dark = w_dark[i];
            w_cur_dp   = dp_mask[i];
            w_show_en[i] = w_dark[i];
         end
      end

      if (w_cur_dark) begin
         w_show_sseg = 8'hFF;
      end else begin
         w_show_sseg = f_decode(w_cur_val);
         if (w_cur_dp) begin
            w_show_sseg[7] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Scan FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_GUARD;
         r_cnt        <= '0;
         r_sseg       <= 8'hFF;
         r_en         <= '1;
         r_digit_idx  <= 3'd0;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_sseg       <= w_sseg_nxt;
         r_en         <= w_en_nxt;
         r_digit_idx  <= w_idx_nxt;
         r_frame_tick <= w_tick_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Scan FSM: next state and registered outputs. The slot pattern is
   // captured on the GUARD->SHOW edge and then held, so writes or mask
   // changes mid-slot never tear the visible digit.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + c_CNT_W'(1);
      w_sseg_nxt  = r_sseg;
      w_en_nxt    = r_en;
      w_idx_nxt   = r_digit_idx;
      w_tick_nxt  = 1'b0;

      case (r_state)
         ST_GUARD: begin
            if (r_cnt == c_GUARD_LAST) begin
               w_state_nxt = ST_SHOW;
               w_cnt_nxt   = '0;
               w_sseg_nxt  = w_show_sseg;
               w_en_nxt    = w_show_en;
            end
         end
         ST_SHOW: begin
            if (r_cnt == c_SHOW_LAST) begin
               w_state_nxt = ST_GUARD;
               w_cnt_nxt   = '0;
               w_sseg_nxt  = 8'hFF;
               w_en_nxt    = '1;
               if (r_digit_idx == c_IDX_LAST) begin
                  w_idx_nxt  = 3'd0;
                  w_tick_nxt = 1'b1;
               end else begin
                  w_idx_nxt  = r_digit_idx + 3'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_GUARD;
            w_cnt_nxt   = '0;
            w_sseg_nxt  = 8'hFF;
            w_en_nxt    = '1;
         end
      endcase
   end

   assign sseg       = r_sseg;
   assign en         = r_en;
   assign digit_idx  = r_digit_idx;
   assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
//=============================================================================
// Module      : tb_sseg_scan_ctrl
// Description : Self-checking bench for sseg_scan_ctrl (CLK_DIV=4, GUARD=2,
//               DIGITS=6). A timeline model predicts the outputs from the
//               number of clock edges since reset release and a copy of the
//               digit values.
// Revision    : 1.0 - initial release
//=============================================================================
module tb_sseg_scan_ctrl;

   localparam int c_CLK_DIV = 4;
   localparam int c_GUARD   = 2;
   localparam int c_DIGITS  = 6;
   localparam int c_PERIOD  = c_CLK_DIV + c_GUARD;
   localparam int c_FRAME   = c_DIGITS * c_PERIOD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] dp_mask = '0;
   logic [5:0] blank_mask = '0;
   logic       lz_suppress = 1'b0;
   logic [7:0] sseg;
   logic [5:0] en;
   logic [2:0] digit_idx;
   logic       frame_tick;

   sseg_scan_ctrl_if wr_if ();

   sseg_scan_ctrl #(
      .CLK_DIV (c_CLK_DIV),
      .GUARD   (c_GUARD),
      .DIGITS  (c_DIGITS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr          (wr_if.slave),
      .dp_mask     (dp_mask),
      .blank_mask  (blank_mask),
      .lz_suppress (lz_suppress),
      .sseg        (sseg),
      .en          (en),
      .digit_idx   (digit_idx),
      .frame_tick  (frame_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         k = 0;              // clock edges since reset release
   logic [3:0] mdig [c_DIGITS];
   logic [7:0] lat_sseg = 8'hFF;
   logic [5:0] lat_en = 6'h3F;
   logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
      end
   endtask

   task automatic model_clear();
      k = 0;
      for (int i = 0; i < c_DIGITS; i++) mdig[i] = 4'd0;
      lat_sseg = 8'hFF;
      lat_en   = 6'h3F;
   endtask

   // One clock: drive the write port, predict, take the edge, compare.
   task automatic step(input logic we, input logic [2:0] a, input logic [3:0] d);
      int   kn, m, s;
      logic allz, dark;
      @(negedge clk);
      wr_if.wr_en   = we;
      wr_if.wr_addr = a;
      wr_if.wr_data = d;
      kn = k + 1;
      m  = kn % c_PERIOD;
      s  = (kn / c_PERIOD) % c_DIGITS;
      if (m == c_GUARD) begin
         // slot starts: capture pattern from values held before this edge
         allz = 1'b1;
         for (int j = s; j < c_DIGITS; j++) if (mdig[j] != 4'd0) allz = 1'b0;
         dark = blank_mask[s] || (lz_suppress && s >= 1 && allz);
         if (dark) begin
            lat_sseg = 8'hFF;
            lat_en   = 6'h3F;
         end else begin
            lat_sseg = dec_tab[mdig[s]] & (dp_mask[s] ? 8'h7F : 8'hFF);
            lat_en   = 6'h3F & ~(6'd1 << s);
         end
      end
      @(posedge clk);
      #1;
      k = kn;
      if (we && a < 3'd6) mdig[a] = d;
      chk("sseg",       32'(sseg),       (m >= c_GUARD) ? 32'(lat_sseg) : 32'hFF);
      chk("en",         32'(en),         (m >= c_GUARD) ? 32'(lat_en)   : 32'h3F);
      chk("digit_idx",  32'(digit_idx),  32'(s));
      chk("frame_tick", 32'(frame_tick), (kn % c_FRAME == 0) ? 32'd1 : 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'd0);
   endtask

   task automatic idle_until_phase(input int phase);
      for (int i = 0; i < c_FRAME; i++) begin
         if ((k % c_FRAME) == phase) break;
         step(1'b0, 3'd0, 4'd0);
      end
   endtask

   initial begin
      wr_if.wr_en   = 1'b0;
      wr_if.wr_addr = 3'd0;
      wr_if.wr_data = 4'd0;
      model_clear();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sseg", 32'(sseg), 32'hFF);
      chk("rst_en",   32'(en),   32'h3F);
      chk("rst_idx",  32'(digit_idx), 32'd0);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      rst_n = 1'b1;

      // Load 1..6 and scan full frames
      for (int i = 0; i < 6; i++) step(1'b1, 3'(i), 4'(i + 1));
      idle(2 * c_FRAME);

      // Write to digit 2 during its slot, then an out-of-range write
      idle_until_phase(2 * c_PERIOD + c_GUARD + 1);
      step(1'b1, 3'd2, 4'd8);
      step(1'b1, 3'd6, 4'd9);
      step(1'b1, 3'd7, 4'd5);
      idle(c_FRAME + 4);

      // Leading-zero suppression
      lz_suppress = 1'b1;
      step(1'b1, 3'd5, 4'd0);
      step(1'b1, 3'd4, 4'd0);
      step(1'b1, 3'd3, 4'd0);
      step(1'b1, 3'd2, 4'd0);
      step(1'b1, 3'd1, 4'd4);
      step(1'b1, 3'd0, 4'd2);
      idle(c_FRAME + 6);
      step(1'b1, 3'd1, 4'd0);
      step(1'b1, 3'd0, 4'd0);
      idle(c_FRAME + 6);

      // Decimal point and blanking on digit 2
      lz_suppress = 1'b0;
      dp_mask = 6'b000100;
      step(1'b1, 3'd2, 4'd3);
      idle(c_FRAME + 3);
      blank_mask = 6'b000100;
      idle(c_FRAME + 3);
      dp_mask    = 6'b000000;
      blank_mask = 6'b000000;

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            dp_mask     = 6'($urandom);
            blank_mask  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            lz_suppress = 1'($urandom);
         end
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0);
      end
      dp_mask = '0;
      blank_mask = '0;
      lz_suppress = 1'b0;
      step(1'b1, 3'd3, 4'hA);
      step(1'b1, 3'd5, 4'hE);

      // Asynchronous reset in the middle of a lit slot
      idle_until_phase(3 * c_PERIOD + c_GUARD + 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sseg", 32'(sseg), 32'hFF);
      chk("mid_rst_en",   32'(en),   32'h3F);
      chk("mid_rst_idx",  32'(digit_idx), 32'd0);
      chk("mid_rst_tick", 32'(frame_tick), 32'd0);
      @(posedge clk);
      #1;
      model_clear();
      rst_n = 1'b1;
      idle(c_FRAME + 6);

      wr_if.wr_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
